// File: rtl/disparity_wta.sv
// Winner-take-all disparity search over a stream of per-candidate Hamming costs.
// Optional uniqueness check (best vs second-best gap) via DISPARITY_WTA_UNIQUENESS_EN.
module disparity_wta #(
   parameter int COST_WIDTH  = 4,
   parameter int MAX_DISP    = 64,
   parameter int DISP_WIDTH  = $clog2(MAX_DISP),
   parameter int UNIQ_MARGIN = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COST_WIDTH-1:0] cost_in,
   input  logic                  cost_valid,
   input  logic                  cost_first,
   input  logic                  cost_last,
   output logic [DISP_WIDTH-1:0] disp_out,
   output logic [COST_WIDTH-1:0] min_cost_out,
   output logic                  disp_valid,
   output logic                  disp_unique,
   output logic                  disp_err
);

   localparam logic IDLE   = 1'b0;
   localparam logic SEARCH = 1'b1;

   localparam logic [DISP_WIDTH:0] CNT_LAST = (DISP_WIDTH+1)'(MAX_DISP - 1);
   localparam logic [DISP_WIDTH:0] CNT_ONE  = (DISP_WIDTH+1)'(1);

   logic                  state_q, st_d;
   logic [COST_WIDTH-1:0] min_q, min_d;
   logic [DISP_WIDTH-1:0] best_q, best_d;
   logic [DISP_WIDTH:0]   cnt_q, cnt_d;

   logic                  lt;
   logic [COST_WIDTH-1:0] nx_min;
   logic [DISP_WIDTH-1:0] nx_best;
   logic                  last_slot;

   logic                  emit;
   logic [DISP_WIDTH-1:0] e_disp;
   logic [COST_WIDTH-1:0] e_cost;
   logic                  e_err;
   logic                  e_uniq;

`ifdef DISPARITY_WTA_UNIQUENESS_EN
   logic [COST_WIDTH-1:0] sec_q, sec_d, nx_sec;

   function automatic logic uniq_f(
      input logic [COST_WIDTH-1:0] s,
      input logic [COST_WIDTH-1:0] m,
      input logic                  single
   );
      logic [COST_WIDTH:0] gap;
      gap = (s >= m) ? ({1'b0, s} - {1'b0, m}) : '0;
      return single || (32'(gap) >= 32'(UNIQ_MARGIN));
   endfunction

   assign nx_sec = lt ? min_q : ((cost_in < sec_q) ? cost_in : sec_q);
`endif

   assign lt        = cost_in < min_q;
   assign nx_min    = lt ? cost_in : min_q;
   assign nx_best   = lt ? cnt_q[DISP_WIDTH-1:0] : best_q;
   assign last_slot = cnt_q == CNT_LAST;

   always_comb begin
      st_d   = state_q;
      min_d  = min_q;
      best_d = best_q;
      cnt_d  = cnt_q;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
      sec_d  = sec_q;
`endif
      emit   = 1'b0;
      e_disp = best_q;
      e_cost = min_q;
      e_err  = 1'b0;
      e_uniq = 1'b1;
      if (cost_valid) begin
         if (state_q == IDLE) begin
            if (cost_first) begin
               min_d  = cost_in;
               best_d = '0;
               cnt_d  = CNT_ONE;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
               sec_d  = '1;
`endif
               if (cost_last) begin
                  emit   = 1'b1;
                  e_disp = '0;
                  e_cost = cost_in;
               end else begin
                  st_d = SEARCH;
               end
            end
         end else if (cost_first) begin
            // abandoned pixel reports its partial result; new pixel starts here
            emit   = 1'b1;
            e_err  = 1'b1;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
            e_uniq = uniq_f(sec_q, min_q, cnt_q == CNT_ONE);
            sec_d  = '1;
`endif
            min_d  = cost_in;
            best_d = '0;
            cnt_d  = CNT_ONE;
            st_d   = cost_last ? IDLE : SEARCH;
         end else begin
            min_d  = nx_min;
            best_d = nx_best;
            cnt_d  = cnt_q + CNT_ONE;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
            sec_d  = nx_sec;
`endif
            if (cost_last || last_slot) begin
               emit   = 1'b1;
               e_disp = nx_best;
               e_cost = nx_min;
               e_err  = !cost_last;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
               e_uniq = uniq_f(nx_sec, nx_min, 1'b0);
`endif
               st_d   = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         min_q        <= '0;
         best_q       <= '0;
         cnt_q        <= '0;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
         sec_q        <= '0;
`endif
         disp_out     <= '0;
         min_cost_out <= '0;
         disp_valid   <= 1'b0;
         disp_unique  <= 1'b0;
         disp_err     <= 1'b0;
      end else begin
         state_q    <= st_d;
         min_q      <= min_d;
         best_q     <= best_d;
         cnt_q      <= cnt_d;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
         sec_q      <= sec_d;
`endif
         disp_valid <= emit;
         if (emit) begin
            disp_out     <= e_disp;
            min_cost_out <= e_cost;
            disp_err     <= e_err;
         end
`ifdef DISPARITY_WTA_UNIQUENESS_EN
         if (emit) disp_unique <= e_uniq;
`else
         disp_unique <= emit & e_uniq;
`endif
      end
   end

endmodule

// File: tb/tb_disparity_wta.sv
// Scoreboard bench for disparity_wta: directed pixels, queued expectations,
// negedge monitor comparing each disp_valid pulse.
module tb_disparity_wta;

   localparam int CW = 4;
   localparam int MD = 64;
   localparam int DW = 6;
`ifdef DISPARITY_WTA_UNIQUENESS_EN
   localparam bit UNQ = 1'b1;
`else
   localparam bit UNQ = 1'b0;
`endif

   typedef struct {
      int d;
      int c;
      int u;
      int e;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] cost_in;
   logic          cost_valid;
   logic          cost_first;
   logic          cost_last;
   logic [DW-1:0] disp_out;
   logic [CW-1:0] min_cost_out;
   logic          disp_valid;
   logic          disp_unique;
   logic          disp_err;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;

   disparity_wta #(
      .COST_WIDTH (CW),
      .MAX_DISP   (MD),
      .UNIQ_MARGIN(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cost_in     (cost_in),
      .cost_valid  (cost_valid),
      .cost_first  (cost_first),
      .cost_last   (cost_last),
      .disp_out    (disp_out),
      .min_cost_out(min_cost_out),
      .disp_valid  (disp_valid),
      .disp_unique (disp_unique),
      .disp_err    (disp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // u is the uniqueness result with the check enabled; disabled build always reports 1
   task automatic push(input int d, input int c, input int u, input int e);
      exp_t x;
      x.d = d;
      x.c = c;
      x.u = UNQ ? u : 1;
      x.e = e;
      q.push_back(x);
   endtask

   task automatic send(input int c, input bit f, input bit l);
      cost_in    = CW'(c);
      cost_valid = 1'b1;
      cost_first = f;
      cost_last  = l;
      @(posedge clk);
      #1;
      cost_valid = 1'b0;
      cost_first = 1'b0;
      cost_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && disp_valid) begin
         if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious_pulse: disp_out %0d min_cost %0d err %0d with no result expected at %0t",
                     disp_out, min_cost_out, disp_err, $time);
         end else begin
            exp_t x;
            x = q.pop_front();
            check("disp_out", int'(disp_out), x.d);
            check("min_cost_out", int'(min_cost_out), x.c);
            check("disp_unique", int'(disp_unique), x.u);
            check("disp_err", int'(disp_err), x.e);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      cost_in    = '0;
      cost_valid = 1'b0;
      cost_first = 1'b0;
      cost_last  = 1'b0;
      idle(2);
      check("reset_disp_valid", int'(disp_valid), 0);
      check("reset_disp_out", int'(disp_out), 0);
      check("reset_min_cost", int'(min_cost_out), 0);
      check("reset_disp_unique", int'(disp_unique), 0);
      check("reset_disp_err", int'(disp_err), 0);
      rst = 1'b0;
      idle(1);

      // basic selection, tie keeps lower disparity
      send(5, 1, 0);
      send(3, 0, 0);
      send(7, 0, 0);
      send(3, 0, 0);
      push(1, 3, 0, 0);
      send(6, 0, 1);
      idle(2);

      // gaps between beats
      send(8, 1, 0);
      idle(1);
      send(2, 0, 0);
      idle(1);
      push(1, 2, 0, 0);
      send(2, 0, 1);
      idle(2);

      // single-candidate pixel
      push(0, 4, 1, 0);
      send(4, 1, 1);
      idle(2);

      // overrun: beat 63 closes with error, later beats ignored
      for (int i = 0; i < MD; i++) begin
         if (i == MD - 1) push(63, 0, 1, 1);
         send((i == MD - 1) ? 0 : 8, i == 0, 0);
      end
      send(5, 0, 0);
      send(1, 0, 1);
      idle(3);

      // restart mid-search
      send(6, 1, 0);
      send(1, 0, 0);
      push(1, 1, 1, 1);
      send(4, 1, 0);
      push(1, 2, 1, 0);
      send(2, 0, 1);
      idle(2);

      // reset mid-search discards the pixel
      send(3, 1, 0);
      send(2, 0, 0);
      send(1, 0, 0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("midreset_disp_valid", int'(disp_valid), 0);
      check("midreset_disp_out", int'(disp_out), 0);
      check("midreset_min_cost", int'(min_cost_out), 0);
      check("midreset_disp_unique", int'(disp_unique), 0);
      check("midreset_disp_err", int'(disp_err), 0);
      idle(1);
      send(1, 0, 1);
      idle(1);
      send(7, 1, 0);
      send(1, 0, 0);
      push(1, 1, 1, 0);
      send(9, 0, 1);
      idle(2);

      // uniqueness with margin 2
      send(2, 1, 0);
      send(3, 0, 0);
      push(0, 2, 0, 0);
      send(8, 0, 1);
      idle(2);
      send(2, 1, 0);
      send(5, 0, 0);
      push(0, 2, 1, 0);
      send(8, 0, 1);
      idle(5);

      check("pending_results", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/disparity_wta.md
DISPARITY_WTA -- requirements
Module: disparity_wta

Interface
REQ-001 The block SHALL have parameter COST_WIDTH, default 4, giving the Hamming cost width (8-bit census yields 0..8).
REQ-002 The block SHALL have parameter MAX_DISP, default 64, giving the maximum disparity candidates per pixel.
REQ-003 The block SHALL have parameter DISP_WIDTH, default $clog2(MAX_DISP), giving the disparity index width.
REQ-004 The block SHALL have parameter UNIQ_MARGIN, default 1, giving the minimum required gap between the best and second-best cost.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-007 The block SHALL have port cost_in, input, COST_WIDTH bits: the Hamming cost of the current candidate, from the hamming_distance output.
REQ-008 The block SHALL have port cost_valid, input, 1 bit: qualifies cost_in, cost_first and cost_last.
REQ-009 The block SHALL have port cost_first, input, 1 bit: marks the candidate at disparity 0 of a pixel.
REQ-010 The block SHALL have port cost_last, input, 1 bit: marks the final candidate of a pixel.
REQ-011 The block SHALL have port disp_out, output, DISP_WIDTH bits: the winning disparity.
REQ-012 The block SHALL have port min_cost_out, output, COST_WIDTH bits: the cost of the winning disparity.
REQ-013 The block SHALL have port disp_valid, output, 1 bit: a one-cycle pulse qualifying disp_out, min_cost_out, disp_unique and disp_err.
REQ-014 The block SHALL have port disp_unique, output, 1 bit: uniqueness flag, defined in Configuration.
REQ-015 The block SHALL have port disp_err, output, 1 bit: protocol error on this result (overrun or aborted pixel).

Function
REQ-016 The FSM SHALL have states IDLE and SEARCH.
REQ-017 IDLE SHALL ignore beats without cost_first.
REQ-018 In IDLE, a beat (cost_valid=1) with cost_first=1 SHALL:
- load min=cost_in, best=0, cnt=1;
- go to SEARCH, or emit immediately if cost_last=1.
REQ-019 In SEARCH, each beat SHALL increment cnt and, if cost_in < min (strict), set min=cost_in and best=cnt; ties therefore keep the lowest disparity.
REQ-020 A beat with cost_last=1 SHALL close the pixel and return the FSM to IDLE.
REQ-021 Results SHALL be registered and asserted the cycle after the closing beat (latency 1), with disp_valid high for exactly one cycle.
REQ-022 Gaps (cost_valid=0) SHALL hold all search state; no backpressure exists.
REQ-023 Overrun: if the MAX_DISP-th beat of a pixel carries cost_last=0, that beat SHALL close the pixel with disp_err=1; following beats SHALL be ignored until the next cost_first.
REQ-024 Restart: cost_first=1 in SEARCH SHALL emit the abandoned pixel's partial result with disp_err=1 and simultaneously start the new pixel from this beat.
REQ-025 cost_first and cost_last in the same beat SHALL produce disp_out=0 and min_cost_out=cost_in.
REQ-026 cnt SHALL be DISP_WIDTH+1 bits wide, and cnt SHALL never wrap.
REQ-027 Outputs SHALL hold their last values while disp_valid=0.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL force FSM=IDLE, disp_out=0, min_cost_out=0, disp_valid=0, disp_unique=0 and disp_err=0, and clear min, best and cnt.
REQ-029 Reset mid-search SHALL discard the pixel with no output pulse.
REQ-030 rst SHALL take priority over every beat in the same cycle.

Configuration
REQ-031 Macro DISPARITY_WTA_UNIQUENESS_EN SHALL select uniqueness checking.
REQ-032 When DISPARITY_WTA_UNIQUENESS_EN is defined, the block SHALL track sec, initialised to all-ones at cost_first, as follows:
- new strict min: sec=old min;
- else if cost_in < sec: sec=cost_in.
REQ-033 When DISPARITY_WTA_UNIQUENESS_EN is defined, disp_unique SHALL equal (sec - min >= UNIQ_MARGIN), computed without underflow, and single-candidate pixels SHALL report 1.
REQ-034 When DISPARITY_WTA_UNIQUENESS_EN is undefined, no sec register SHALL exist, and disp_unique SHALL be 1 whenever disp_valid=1 and 0 otherwise.
REQ-035 The port list SHALL be identical in both builds.

Verification
REQ-036 The bench SHALL check basic selection: costs 5,3,7,3,6 (first on beat 0, last on beat 4) -> one cycle later disp_out=1, min_cost_out=3, disp_valid=1 for one cycle, disp_err=0.
REQ-037 The bench SHALL check gaps and single-candidate pixels: costs 8,2,2 with one idle cycle between each beat -> disp_out=1, min_cost_out=2; first+last on cost 4 -> disp_out=0, min_cost_out=4.
REQ-038 The bench SHALL check overrun: 64 beats without cost_last (MAX_DISP=64), cost=8 except beat 63 cost 0 -> disp_out=63, min_cost_out=0, disp_err=1; beat 65 with no cost_first produces no output.
REQ-039 The bench SHALL check restart: costs 6,1, then cost_first with cost 4, then last with cost 2 -> first pulse disp_out=1, min_cost_out=1, disp_err=1; second pulse disp_out=1, min_cost_out=2, disp_err=0.
REQ-040 The bench SHALL check reset mid-search: rst=1 for one cycle after 3 beats -> no disp_valid pulse, all outputs 0; the next pixel is resolved correctly.
REQ-041 The bench SHALL check uniqueness: costs 2,3,8 with the macro defined and UNIQ_MARGIN=2 -> disp_out=0, disp_unique=0; costs 2,5,8 -> disp_unique=1; with the macro undefined, both cases give disp_unique=1.
